// File: rtl/block_fill_responder.sv
// Memory end of the cache fill protocol: returns a whole block one word per cycle
// after a fixed latency, and takes single-word write-through stores while idle.
module block_fill_responder #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int LATENCY         = 4,
    parameter int MEM_ADDR_BITS   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rsp_valid,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  busy
);
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W = CNT_W + 1;
    localparam int LAT_W = 4;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);
    // Beat 0 is loaded into the output registers on the last WAIT edge, so the
    // WAIT phase lasts LATENCY-1 cycles and the counter starts at LATENCY-2.
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  base_reg, base_next;
    logic [LAT_W-1:0]       lat_cnt_reg, lat_cnt_next;
    logic [CNT_W-1:0]       word_cnt_reg, word_cnt_next;
    logic                   rsp_valid_reg, rsp_valid_next;
    logic [ADDR_WIDTH-1:0]  rsp_addr_reg, rsp_addr_next;
    logic                   rsp_last_reg, rsp_last_next;
    logic [DATA_WIDTH-1:0]  rsp_data_reg;
    logic                   rd_en;

    logic [DATA_WIDTH-1:0]  mem [0:(2**MEM_ADDR_BITS)-1];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[OFF_W-1:0], wr_addr[0]};

    always_comb begin
        state_next     = state_reg;
        base_next      = base_reg;
        lat_cnt_next   = lat_cnt_reg;
        word_cnt_next  = word_cnt_reg;
        rsp_valid_next = 1'b0;
        rsp_addr_next  = '0;
        rsp_last_next  = 1'b0;
        rd_en          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    base_next    = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    lat_cnt_next = LAT_LOAD;
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_reg == '0) begin
                    state_next    = ST_STREAM;
                    word_cnt_next = '0;
                    rd_en         = 1'b1;
                end else begin
                    lat_cnt_next = lat_cnt_reg - LAT_W'(1);
                end
            end
            ST_STREAM: begin
                if (word_cnt_reg == LAST_WORD) begin
                    state_next    = ST_IDLE;
                    word_cnt_next = '0;
                end else begin
                    word_cnt_next = word_cnt_reg + CNT_W'(1);
                    rd_en         = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (rd_en) begin
            rsp_valid_next = 1'b1;
            rsp_addr_next  = base_reg | ADDR_WIDTH'({word_cnt_next, 1'b0});
            rsp_last_next  = (word_cnt_next == LAST_WORD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            base_reg      <= '0;
            lat_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_addr_reg  <= '0;
            rsp_last_reg  <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            base_reg      <= base_next;
            lat_cnt_reg   <= lat_cnt_next;
            word_cnt_reg  <= word_cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_addr_reg  <= rsp_addr_next;
            rsp_last_reg  <= rsp_last_next;
            rsp_data_reg  <= rd_en ? mem[rsp_addr_next[MEM_ADDR_BITS:1]] : '0;
        end
    end

    // Stores only land in IDLE, and reads only happen in WAIT/STREAM, so a store
    // and its covering fill never touch the array on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && state_reg == ST_IDLE) begin
            mem[wr_addr[MEM_ADDR_BITS:1]] <= wr_data;
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_addr  = rsp_addr_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_last  = rsp_last_reg;

endmodule

// File: tb/tb_block_fill_responder.sv
// Self-checking bench for block_fill_responder: directed protocol cases plus
// randomized stores/fills against a word-array memory model.
module tb_block_fill_responder;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst, req_valid, wr_en;
    logic [15:0] req_addr, wr_addr, wr_data;
    logic        req_ready, rsp_valid, rsp_last, busy;
    logic [15:0] rsp_addr, rsp_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] model [0:511];

    block_fill_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        model[a[9:1]] = d;
        step();
        wr_en = 1'b0;
    endtask

    // Called in an IDLE cycle; returns in the first IDLE cycle after the block.
    task automatic fill(input logic [15:0] a, input bit hold,
                        input bit st, input logic [15:0] sa, input logic [15:0] sd,
                        input bit junk, input logic [15:0] ja, input logic [15:0] jd);
        logic [15:0] base;
        logic [15:0] ea;
        int beat;
        base = a - (a % 16);
        chk("ready_at_accept", 32'(req_ready), 1);
        req_valid = 1'b1; req_addr = a;
        if (st) begin
            wr_en = 1'b1; wr_addr = sa; wr_data = sd;
            model[sa[9:1]] = sd;
        end
        step();
        req_valid = hold;
        wr_en = 1'b0;
        for (int k = 1; k < LAT + 8; k++) begin
            if (junk) begin
                wr_en = 1'b1; wr_addr = ja; wr_data = jd;
            end
            beat = k - LAT;
            chk("ready_low", 32'(req_ready), 0);
            chk("busy_high", 32'(busy), 1);
            if (beat >= 0) begin
                ea = base + 16'(2 * beat);
                chk("beat_valid", 32'(rsp_valid), 1);
                chk("beat_addr", 32'(rsp_addr), 32'(ea));
                chk("beat_data", 32'(rsp_data), 32'(model[ea[9:1]]));
                chk("beat_last", 32'(rsp_last), (beat == 7) ? 1 : 0);
            end else begin
                chk("wait_valid", 32'(rsp_valid), 0);
                chk("wait_addr", 32'(rsp_addr), 0);
                chk("wait_data", 32'(rsp_data), 0);
                chk("wait_last", 32'(rsp_last), 0);
            end
            step();
        end
        wr_en = 1'b0;
        chk("ready_after", 32'(req_ready), 1);
        chk("valid_after", 32'(rsp_valid), 0);
        $display("fill addr=%h base=%h checks=%0d errors=%0d", a, base, checks, errors);
    endtask

    initial begin
        logic [15:0] ea;
        rst = 1'b1; req_valid = 1'b0; wr_en = 1'b0;
        req_addr = '0; wr_addr = '0; wr_data = '0;

        // Reset held two cycles
        step(); step();
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_last", 32'(rsp_last), 0);
        chk("rst_addr", 32'(rsp_addr), 0);
        chk("rst_data", 32'(rsp_data), 0);
        $display("reset checks=%0d errors=%0d", checks, errors);

        // Give every word of the exercised region a defined value
        for (int i = 0; i < 512; i++) begin
            wr_en = 1'b1; wr_addr = 16'(i * 2); wr_data = '0;
            model[i] = '0;
            step();
        end
        wr_en = 1'b0;

        // Basic fill, with a store attempted during the fill that must be dropped
        store(16'h0042, 16'h1234);
        store(16'h004E, 16'h5678);
        fill(16'h004A, 0, 0, '0, '0, 1, 16'h0040, 16'hAAAA);
        fill(16'h0040, 0, 0, '0, '0, 0, '0, '0);

        // Store and request on the same IDLE edge
        fill(16'h0106, 0, 1, 16'h0100, 16'hBEEF, 0, '0, '0);

        // Request held high across two fills
        fill(16'h0200, 1, 0, '0, '0, 0, '0, '0);
        fill(16'h0200, 0, 0, '0, '0, 0, '0, '0);

        // Reset beats a simultaneous request and store
        rst = 1'b1; req_valid = 1'b1; req_addr = 16'h0300;
        wr_en = 1'b1; wr_addr = 16'h0300; wr_data = 16'h7777;
        step();
        rst = 1'b0; req_valid = 1'b0; wr_en = 1'b0;
        chk("rstpri_ready", 32'(req_ready), 1);
        step();
        chk("rstpri_still_idle", 32'(req_ready), 1);
        chk("rstpri_valid", 32'(rsp_valid), 0);
        fill(16'h0300, 0, 0, '0, '0, 0, '0, '0);

        // Reset in the middle of streaming
        req_valid = 1'b1; req_addr = 16'h004A;
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("mid_valid", 32'(rsp_valid), (k >= LAT) ? 1 : 0);
            if (k >= LAT) begin
                ea = 16'h0040 + 16'(2 * (k - LAT));
                chk("mid_data", 32'(rsp_data), 32'(model[ea[9:1]]));
            end
            if (k == 6) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        chk("abort_valid", 32'(rsp_valid), 0);
        chk("abort_ready", 32'(req_ready), 1);
        chk("abort_last", 32'(rsp_last), 0);
        chk("abort_addr", 32'(rsp_addr), 0);
        step();
        chk("abort_valid2", 32'(rsp_valid), 0);
        fill(16'h0044, 0, 0, '0, '0, 0, '0, '0);

        // Randomized stores and fills over the initialized region
        for (int it = 0; it < 25; it++) begin
            int nst;
            nst = int'($urandom_range(0, 2));
            for (int s = 0; s < nst; s++)
                store(16'($urandom_range(0, 1023)), 16'($urandom));
            fill(16'($urandom_range(0, 1023)), 0,
                 1'($urandom_range(0, 1)), 16'($urandom_range(0, 1023)), 16'($urandom),
                 1'($urandom_range(0, 1)), 16'($urandom_range(0, 1023)), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
